// File: rtl/rpn_pkg.sv
// rpn_pkg: shared opcode and FSM state encodings for the RPN sequencer.
// Used by rpn_alu and rpn_ctrl.

package rpn_pkg;

    // Operator opcodes carried in tok_data[1:0] of an operator token
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    // Sequencer states
    //   state   | meaning
    //   S_IDLE  | ready for a token, stack ports idle
    //   S_PUSH  | push latched operand (dropped if stack full)
    //   S_POP_B | capture top as B and pop it (abort if empty)
    //   S_POP_A | capture top as A and pop it (abort if empty, B lost)
    //   S_EXEC  | push alu(A,B,op) and strobe the result
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PUSH  = 3'd1,
        S_POP_B = 3'd2,
        S_POP_A = 3'd3,
        S_EXEC  = 3'd4
    } state_t;

endpackage

// File: rtl/rpn_alu.sv
// rpn_alu: combinational operator datapath. B is the entry popped first
// (old top), A the one beneath it. All results wrap modulo 2^DW.

module rpn_alu
    import rpn_pkg::*;
#(
    parameter int DW = 4
)
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [1:0]    op,
    output logic [DW-1:0] result
);

    // Select the operation; carry and borrow fall off the top bit
    always_comb begin
        result = '0;
        unique case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rpn_ctrl.sv
// rpn_ctrl: reverse-Polish sequencer and sole driver of the LIFO stack's
// push/pop port. Operands are pushed; operators pop B then A, push the
// result and pulse res_valid for one cycle.
// Optional feature macro: RPN_CTRL_ERR_EN
//   defined   - sticky ovf_err / unf_err registers, cleared by err_clr
//   undefined - ovf_err / unf_err tied low, err_clr ignored
// The abort behaviour on overflow/underflow is the same in both builds.

module rpn_ctrl
    import rpn_pkg::*;
#(
    parameter int DW = 4
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          tok_valid,
    output logic          tok_ready,
    input  logic          tok_is_op,
    input  logic [DW-1:0] tok_data,
    output logic          st_push,
    output logic          st_pop,
    output logic [DW-1:0] st_push_data,
    input  logic [DW-1:0] st_top,
    input  logic          st_empty,
    input  logic          st_full,
    output logic [DW-1:0] res_data,
    output logic          res_valid,
    output logic          ovf_err,
    output logic          unf_err,
    input  logic          err_clr
);

    state_t          r_state;
    logic [DW-1:0]   r_opnd;
    logic [1:0]      r_op;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic [DW-1:0]   r_res;
    logic            r_res_valid;
    logic [DW-1:0]   w_alu_res;

    rpn_alu #(.DW(DW)) u_alu (
        .a      (r_a),
        .b      (r_b),
        .op     (r_op),
        .result (w_alu_res)
    );

    // Token sequencing plus operand/result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_opnd      <= '0;
            r_op        <= OP_ADD;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (tok_valid) begin
                        if (tok_is_op) begin
                            r_op    <= tok_data[1:0];
                            r_state <= S_POP_B;
                        end else begin
                            r_opnd  <= tok_data;
                            r_state <= S_PUSH;
                        end
                    end
                end
                S_PUSH: begin
                    r_state <= S_IDLE;
                end
                S_POP_B: begin
                    if (st_empty) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_b     <= st_top;
                        r_state <= S_POP_A;
                    end
                end
                S_POP_A: begin
                    // B has already left the stack; an abort here loses it
                    if (st_empty) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_a     <= st_top;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_res       <= w_alu_res;
                    r_res_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stack port drive, decoded from state so it is stable all cycle;
    // push and pop live in disjoint states so they never overlap
    always_comb begin
        st_push      = 1'b0;
        st_pop       = 1'b0;
        st_push_data = '0;
        unique case (r_state)
            S_PUSH: begin
                st_push      = ~st_full;
                st_push_data = r_opnd;
            end
            S_POP_B, S_POP_A: begin
                st_pop = ~st_empty;
            end
            S_EXEC: begin
                // two entries were just popped, so there is always room
                st_push      = 1'b1;
                st_push_data = w_alu_res;
            end
            default: begin
                st_push = 1'b0;
            end
        endcase
    end

    assign tok_ready = (r_state == S_IDLE);
    assign res_data  = r_res;
    assign res_valid = r_res_valid;

`ifdef RPN_CTRL_ERR_EN
    logic r_ovf_err;
    logic r_unf_err;
    logic w_ovf_set;
    logic w_unf_set;

    assign w_ovf_set = (r_state == S_PUSH) && st_full;
    assign w_unf_set = ((r_state == S_POP_B) || (r_state == S_POP_A)) && st_empty;

    // Sticky error flags; a same-cycle set beats err_clr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf_err <= 1'b0;
            r_unf_err <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf_err <= 1'b1;
            end else if (err_clr) begin
                r_ovf_err <= 1'b0;
            end
            if (w_unf_set) begin
                r_unf_err <= 1'b1;
            end else if (err_clr) begin
                r_unf_err <= 1'b0;
            end
        end
    end

    assign ovf_err = r_ovf_err;
    assign unf_err = r_unf_err;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr;
    assign ovf_err          = 1'b0;
    assign unf_err          = 1'b0;
`endif

endmodule

// File: tb/tb_rpn_ctrl.sv
// tb_rpn_ctrl: rpn_ctrl driving a depth-4 behavioural LIFO; directed
// cases followed by random tokens, all checked against a queue-based
// reverse-Polish calculator model.

module tb_rpn_ctrl;

    localparam int DW    = 4;
    localparam int DEPTH = 4;

`ifdef RPN_CTRL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          tok_valid;
    logic          tok_ready;
    logic          tok_is_op;
    logic [DW-1:0] tok_data;
    logic          st_push;
    logic          st_pop;
    logic [DW-1:0] st_push_data;
    logic [DW-1:0] st_top;
    logic          st_empty;
    logic          st_full;
    logic [DW-1:0] res_data;
    logic          res_valid;
    logic          ovf_err;
    logic          unf_err;
    logic          err_clr;

    rpn_ctrl #(.DW(DW)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .tok_valid    (tok_valid),
        .tok_ready    (tok_ready),
        .tok_is_op    (tok_is_op),
        .tok_data     (tok_data),
        .st_push      (st_push),
        .st_pop       (st_pop),
        .st_push_data (st_push_data),
        .st_top       (st_top),
        .st_empty     (st_empty),
        .st_full      (st_full),
        .res_data     (res_data),
        .res_valid    (res_valid),
        .ovf_err      (ovf_err),
        .unf_err      (unf_err),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural LIFO sharing the reset net
    logic [DW-1:0] stk_mem [DEPTH];
    logic [2:0]    stk_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            stk_cnt <= 3'd0;
        end else if (st_push && stk_cnt < 3'd4) begin
            stk_mem[stk_cnt[1:0]] <= st_push_data;
            stk_cnt <= stk_cnt + 3'd1;
        end else if (st_pop && stk_cnt != 3'd0) begin
            stk_cnt <= stk_cnt - 3'd1;
        end
    end

    assign st_top   = (stk_cnt != 3'd0) ? stk_mem[2'(stk_cnt - 3'd1)] : 4'h0;
    assign st_empty = (stk_cnt == 3'd0);
    assign st_full  = (stk_cnt == 3'd4);

    int n_checks = 0;
    int n_errors = 0;
    int n_push   = 0;
    int n_pop    = 0;
    int n_res    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            if (st_push) n_push++;
            if (st_pop)  n_pop++;
            if (res_valid) n_res++;
        end
    end

    always @(negedge clk) begin
        if (rst && st_push && st_pop) chk("push_pop_overlap", 32'd1, 32'd0);
    end

    // reference calculator state
    logic [DW-1:0] m_stk [$];
    logic [DW-1:0] m_res;
    bit            m_ovf;
    bit            m_unf;

    function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [1:0] op);
        int r;
        case (op)
            2'd0:    r = int'(a) + int'(b);
            2'd1:    r = int'(a) - int'(b) + 16;
            2'd2:    r = int'(a & b);
            default: r = int'(a ^ b);
        endcase
        return 4'(r % 16);
    endfunction

    function automatic logic [31:0] pack_dut();
        logic [31:0] v;
        v = '0;
        v[30:28] = stk_cnt;
        for (int i = 0; i < DEPTH; i++)
            if (i < int'(stk_cnt)) v[4*i +: 4] = stk_mem[i];
        return v;
    endfunction

    function automatic logic [31:0] pack_model();
        logic [31:0] v;
        v = '0;
        v[30:28] = 3'(m_stk.size());
        for (int i = 0; i < m_stk.size(); i++) v[4*i +: 4] = m_stk[i];
        return v;
    endfunction

    task automatic model_reset();
        m_stk.delete();
        m_res = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"},   32'(tok_ready),    32'd1);
        chk({tag, "_push"},  32'(st_push),      32'd0);
        chk({tag, "_pop"},   32'(st_pop),       32'd0);
        chk({tag, "_pdata"}, 32'(st_push_data), 32'd0);
        chk({tag, "_res"},   32'(res_data),     32'd0);
        chk({tag, "_rv"},    32'(res_valid),    32'd0);
        chk({tag, "_ovf"},   32'(ovf_err),      32'd0);
        chk({tag, "_unf"},   32'(unf_err),      32'd0);
        chk({tag, "_stk"},   32'(stk_cnt),      32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #2;
        chk_reset_vals(tag);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic do_clr();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        chk("clr_ovf", 32'(ovf_err), 32'd0);
        chk("clr_unf", 32'(unf_err), 32'd0);
    endtask

    // Present one token, wait for tok_ready to return, compare with model.
    // clr_during holds err_clr for the single edge after acceptance.
    task automatic send_tok(input bit is_op, input logic [DW-1:0] d, input bit clr_during);
        int cyc, p0, q0, exp_cyc, exp_push, exp_pop;
        bit exp_rv, ev_ovf, ev_unf;
        logic [DW-1:0] a, b;
        p0 = n_push;
        q0 = n_pop;
        exp_push = 0; exp_pop = 0; exp_rv = 1'b0; ev_ovf = 1'b0; ev_unf = 1'b0;
        if (!is_op) begin
            exp_cyc = 1;
            if (m_stk.size() < DEPTH) begin
                m_stk.push_back(d);
                exp_push = 1;
            end else begin
                ev_ovf = 1'b1;
            end
        end else if (m_stk.size() == 0) begin
            exp_cyc = 1;
            ev_unf  = 1'b1;
        end else if (m_stk.size() == 1) begin
            exp_cyc = 2;
            void'(m_stk.pop_back());
            exp_pop = 1;
            ev_unf  = 1'b1;
        end else begin
            exp_cyc = 3;
            b = m_stk.pop_back();
            a = m_stk.pop_back();
            m_res = ref_alu(a, b, d[1:0]);
            m_stk.push_back(m_res);
            exp_pop  = 2;
            exp_push = 1;
            exp_rv   = 1'b1;
        end
        if (!ERR_EN) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (clr_during) begin
            m_ovf = ev_ovf;
            m_unf = ev_unf;
        end else begin
            m_ovf = m_ovf | ev_ovf;
            m_unf = m_unf | ev_unf;
        end

        tok_valid = 1'b1;
        tok_is_op = is_op;
        tok_data  = d;
        @(posedge clk); #1;
        tok_valid = 1'b0;
        tok_data  = 4'(~d);
        if (clr_during) err_clr = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            err_clr = 1'b0;
            cyc++;
        end while (!tok_ready && cyc < 10);

        chk("busy_cycles", 32'(cyc),        32'(exp_cyc));
        chk("res_valid",   32'(res_valid),  32'(exp_rv));
        chk("res_data",    32'(res_data),   32'(m_res));
        chk("push_count",  32'(n_push - p0), 32'(exp_push));
        chk("pop_count",   32'(n_pop - q0),  32'(exp_pop));
        chk("ovf_err",     32'(ovf_err),    32'(m_ovf));
        chk("unf_err",     32'(unf_err),    32'(m_unf));
        chk("stack",       pack_dut(),      pack_model());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        rst       = 1'b0;
        tok_valid = 1'b0;
        tok_is_op = 1'b0;
        tok_data  = '0;
        err_clr   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset("rst0");

        // 3 5 + -> 8
        send_tok(1'b0, 4'h3, 1'b0);
        send_tok(1'b0, 4'h5, 1'b0);
        send_tok(1'b1, 4'h0, 1'b0);
        chk("tp1_res", 32'(res_data), 32'h8);
        chk("tp1_top", 32'(st_top),   32'h8);
        chk("tp1_cnt", 32'(stk_cnt),  32'd1);

        // 3 5 - -> E
        do_reset("rst1");
        send_tok(1'b0, 4'h3, 1'b0);
        send_tok(1'b0, 4'h5, 1'b0);
        send_tok(1'b1, 4'h1, 1'b0);
        chk("tp2_res", 32'(res_data), 32'hE);

        // 9 9 + -> 2 (wrap), then 6 ^ -> 4; upper opcode bits ignored
        do_reset("rst2");
        send_tok(1'b0, 4'h9, 1'b0);
        send_tok(1'b0, 4'h9, 1'b0);
        send_tok(1'b1, 4'hC, 1'b0);
        chk("tp3_res", 32'(res_data), 32'h2);
        send_tok(1'b0, 4'h6, 1'b0);
        send_tok(1'b1, 4'h7, 1'b0);
        chk("tp3_xor", 32'(res_data), 32'h4);

        // underflow on empty (err_clr same cycle: set wins), then on one entry
        do_reset("rst3");
        send_tok(1'b1, 4'h0, 1'b1);
        send_tok(1'b0, 4'h7, 1'b0);
        send_tok(1'b1, 4'h2, 1'b0);
        chk("tp4_empty", 32'(st_empty), 32'd1);
        do_clr();

        // overflow: 1 2 3 4 5, then + -> 7
        do_reset("rst4");
        for (int i = 1; i <= 5; i++) send_tok(1'b0, 4'(i), 1'b0);
        chk("tp5_top", 32'(st_top), 32'h4);
        send_tok(1'b1, 4'h0, 1'b0);
        chk("tp5_res", 32'(res_data), 32'h7);
        do_clr();

        // reset during POP_A aborts the operator
        do_reset("rst5");
        send_tok(1'b0, 4'h3, 1'b0);
        send_tok(1'b0, 4'h5, 1'b0);
        tok_valid = 1'b1;
        tok_is_op = 1'b1;
        tok_data  = 4'h0;
        @(posedge clk); #1;
        tok_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        chk_reset_vals("midrst");
        @(posedge clk); #1;
        rst = 1'b1;
        r0 = n_res;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_rv", 32'(n_res - r0), 32'd0);
        chk("midrst_rdy",   32'(tok_ready),  32'd1);
        model_reset();

        // random token stream
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 24) == 0) begin
                do_clr();
            end else begin
                send_tok($urandom_range(0, 9) < 4, 4'($urandom), $urandom_range(0, 11) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
